rx_word_packer: RTL and testbench

RX_WORD_PACKER -- requirements
Module: rx_word_packer

---
 rtl/rx_word_packer.sv | 126 ++++++++++++
 tb/tb_rx_word_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_packer.sv
// rtl/rx_word_packer.sv - packs received bytes little-endian into words queued in a FWFT FIFO (optional RX_WORD_PACKER_TIMEOUT_EN)
module rx_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid_in,
  output logic [8*BYTES_PER_WORD-1:0] word_out,
  output logic                        word_valid_out,
  input  logic                        word_ready_in,
  output logic                        overflow_out,
  output logic                        timeout_out,
  output logic                        busy_out
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int CNT_W  = $clog2(BYTES_PER_WORD);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;

  logic [CNT_W-1:0]  r_byte_cnt;
  logic [WORD_W-1:0] r_partial;
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic              r_overflow;

  logic              w_last;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_expire;
  logic [WORD_W-1:0] w_word;

  // The final byte always lands in the top lane, so the completed word is
  // formed combinationally and written to the FIFO at the same edge.
  assign w_last  = byte_valid_in && (r_byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign w_word  = {byte_in, r_partial[WORD_W-9:0]};
  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_pop   = !w_empty && word_ready_in;
  assign w_push  = w_last && (!w_full || w_pop);

  assign word_valid_out = !w_empty;
  assign word_out       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign overflow_out   = r_overflow;
  assign busy_out       = (r_byte_cnt != '0);

`ifdef RX_WORD_PACKER_TIMEOUT_EN
  logic [23:0] r_to_cnt;
  logic        r_timeout;

  // A byte in the expiry cycle wins, so expiry requires no byte this cycle.
  assign w_expire    = busy_out && !byte_valid_in && (r_to_cnt == 24'(TIMEOUT_CYCLES - 1));
  assign timeout_out = r_timeout;

  // Idle-clock counter between bytes of a word, plus the one-cycle pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (byte_valid_in || w_expire || !busy_out) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 24'd1;
      end
    end
  end
`else
  assign w_expire    = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // Byte lane counter and partial-word assembly.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_byte_cnt <= '0;
      r_partial  <= '0;
    end else if (byte_valid_in) begin
      r_partial[r_byte_cnt*8 +: 8] <= byte_in;
      r_byte_cnt <= w_last ? '0 : r_byte_cnt + CNT_W'(1);
    end else if (w_expire) begin
      r_byte_cnt <= '0;
    end
  end

  // FIFO storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_last && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_word_packer.sv
// tb/tb_rx_word_packer.sv - directed self-checking bench for rx_word_packer
module tb_rx_word_packer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid_in = 1'b0;
  logic [31:0] word_out;
  logic        word_valid_out;
  logic        word_ready_in = 1'b0;
  logic        overflow_out;
  logic        timeout_out;
  logic        busy_out;

  int checks = 0;
  int failures = 0;

  rx_word_packer #(
    .BYTES_PER_WORD(4),
    .FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .byte_in(byte_in),
    .byte_valid_in(byte_valid_in),
    .word_out(word_out),
    .word_valid_out(word_valid_out),
    .word_ready_in(word_ready_in),
    .overflow_out(overflow_out),
    .timeout_out(timeout_out),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    byte_in = b;
    byte_valid_in = 1'b1;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
    byte_in = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, word_valid_out, 1);
    check({tag, "_word"}, word_out, exp);
    word_ready_in = 1'b1;
    @(negedge clk_in);
    word_ready_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    word_ready_in = 1'b0;
    byte_valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  logic [31:0] words [5];
  logic [7:0]  hold_byte;
  int          pulses;
  int          pulse_at;

  initial begin
    words[0] = 32'hA3A2A1A0;
    words[1] = 32'hB3B2B1B0;
    words[2] = 32'hC3C2C1C0;
    words[3] = 32'hD3D2D1D0;
    words[4] = 32'hE3E2E1E0;

    // reset state
    repeat (2) @(negedge clk_in);
    check("rst_valid", word_valid_out, 0);
    check("rst_word", word_out, 0);
    check("rst_overflow", overflow_out, 0);
    check("rst_timeout", timeout_out, 0);
    check("rst_busy", busy_out, 0);
    rst_in = 1'b0;

    // single word, consumer ready
    word_ready_in = 1'b1;
    send_byte(8'h11);
    check("w1_busy", busy_out, 1);
    check("w1_valid_early", word_valid_out, 0);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("w1_valid", word_valid_out, 1);
    check("w1_word", word_out, 32'h44332211);
    check("w1_busy_done", busy_out, 0);
    @(negedge clk_in);
    check("w1_valid_one_cycle", word_valid_out, 0);
    word_ready_in = 1'b0;

    // overflow: five words into a depth-4 FIFO with no consumer
    for (int i = 0; i < 4; i++) send_word(words[i]);
    check("ovf_not_yet", overflow_out, 0);
    send_word(words[4]);
    check("ovf_set", overflow_out, 1);
    check("ovf_busy", busy_out, 0);
    for (int i = 0; i < 3; i++) begin
      check("ovf_hold_word", word_out, words[0]);
      @(negedge clk_in);
    end
    pop_check("ovf_pop0", words[0]);
    pop_check("ovf_pop1", words[1]);
    pop_check("ovf_pop2", words[2]);
    pop_check("ovf_pop3", words[3]);
    check("ovf_empty", word_valid_out, 0);
    check("ovf_sticky", overflow_out, 1);

    // full FIFO, final byte coincides with a pop
    do_reset();
    check("full_ovf_cleared", overflow_out, 0);
    for (int i = 0; i < 4; i++) send_word(words[i]);
    for (int k = 0; k < 3; k++) send_byte(words[4][8*k +: 8]);
    @(negedge clk_in);
    byte_in = words[4][31:24];
    byte_valid_in = 1'b1;
    word_ready_in = 1'b1;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
    word_ready_in = 1'b0;
    check("full_no_ovf", overflow_out, 0);
    pop_check("full_pop1", words[1]);
    pop_check("full_pop2", words[2]);
    pop_check("full_pop3", words[3]);
    pop_check("full_pop4", words[4]);
    check("full_empty", word_valid_out, 0);

    // asynchronous reset mid-word with two words queued
    do_reset();
    send_word(words[0]);
    send_word(words[1]);
    send_byte(8'h55);
    send_byte(8'h66);
    #2 rst_in = 1'b1;
    #1;
    check("arst_valid", word_valid_out, 0);
    check("arst_busy", busy_out, 0);
    check("arst_word", word_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    word_ready_in = 1'b1;
    send_word(32'h0D0C0B0A);
    check("arst_clean_word", word_out, 32'h0D0C0B0A);
    @(negedge clk_in);
    check("arst_old_gone", word_valid_out, 0);
    word_ready_in = 1'b0;

    // byte_in toggling without valid leaves the partial word alone
    send_byte(8'h5A);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      byte_in = 8'($urandom);
    end
    check("idle_busy", busy_out, 1);
    check("idle_valid", word_valid_out, 0);
    send_byte(8'h6B);
    send_byte(8'h7C);
    send_byte(8'h8D);
    check("idle_word", word_out, 32'h8D7C6B5A);
    pop_check("idle_pop", 32'h8D7C6B5A);

    // partial-word timeout behaviour
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulses = 0;
    pulse_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_in);
      if (timeout_out) begin
        pulses++;
        pulse_at = i;
      end
    end
`ifdef RX_WORD_PACKER_TIMEOUT_EN
    check("to_pulses", pulses, 1);
    check("to_pulse_at", pulse_at, 16);
    check("to_busy", busy_out, 0);
    send_word(32'h04030201);
    check("to_next_word", word_out, 32'h04030201);
`else
    check("noto_pulses", pulses, 0);
    check("noto_busy", busy_out, 1);
    send_byte(8'hCC);
    send_byte(8'hDD);
    check("noto_word", word_out, 32'hDDCCBBAA);
`endif
    check("final_valid", word_valid_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
